// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller driving a 512x32 byte-enabled SRAM.
// Optional build macro DCACHE_FLUSH_EN adds flush_req/flush_busy for invalidating the whole cache.
module dcache_ctrl #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INDEX_WIDTH = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cpu_req,
  input  logic                   cpu_we,
  input  logic [ADDR_WIDTH-1:0]  cpu_addr,
  input  logic [31:0]            cpu_wdata,
  input  logic [3:0]             cpu_be,
  output logic                   cpu_ready,
  output logic [31:0]            cpu_rdata,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [31:0]            mem_wdata,
  output logic [3:0]             mem_be,
  input  logic                   mem_ack,
  input  logic [31:0]            mem_rdata,
  output logic                   sram_wr_en,
  output logic [INDEX_WIDTH+1:0] sram_wr_addr,
  output logic [31:0]            sram_wr_data,
  output logic [3:0]             sram_wr_byte_en,
  output logic [INDEX_WIDTH+1:0] sram_rd_addr,
  input  logic [31:0]            sram_rd_data
`ifdef DCACHE_FLUSH_EN
  ,
  input  logic                   flush_req,
  output logic                   flush_busy
`endif
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 4;
  localparam int LINES = 1 << INDEX_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, RESP, WRITE_MEM} state_t;

  state_t                  state, next;
  logic                    req_we;
  logic [ADDR_WIDTH-1:2]   req_addr;
  logic [31:0]             req_wdata;
  logic [3:0]              req_be;
  logic [1:0]              beat;
  logic [31:0]             cap_q;
  logic [31:0]             rdata_q;
  logic [LINES-1:0]        valid;
  logic [TAG_W-1:0]        tag_mem [LINES];
  logic                    hit;
  logic                    flush_go;
  logic                    flush_now;
  logic                    unused_byte_offset;

  logic [INDEX_WIDTH-1:0]  req_index;
  logic [1:0]              req_word;
  logic [TAG_W-1:0]        req_tag;

  assign req_index = req_addr[INDEX_WIDTH+3:4];
  assign req_word  = req_addr[3:2];
  assign req_tag   = req_addr[ADDR_WIDTH-1:INDEX_WIDTH+4];
  assign hit       = valid[req_index] && (tag_mem[req_index] == req_tag);

  // SRAM read is issued straight from the CPU address so data is ready in LOOKUP
  assign sram_rd_addr       = cpu_addr[INDEX_WIDTH+3:2];
  assign unused_byte_offset = ^cpu_addr[1:0];

`ifdef DCACHE_FLUSH_EN
  logic flush_pend;
  assign flush_go   = flush_req || flush_pend;
  assign flush_busy = flush_pend;
`else
  assign flush_go = 1'b0;
`endif

  always_comb begin
    next            = state;
    cpu_ready       = 1'b0;
    cpu_rdata       = rdata_q;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_be          = '0;
    sram_wr_en      = 1'b0;
    sram_wr_addr    = '0;
    sram_wr_data    = '0;
    sram_wr_byte_en = '0;
    flush_now       = 1'b0;
    case (state)
      IDLE: begin
        if (flush_go) flush_now = 1'b1;
        else if (cpu_req) next = LOOKUP;
      end
      LOOKUP: begin
        if (!req_we) begin
          if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = sram_rd_data;
            next      = IDLE;
          end else begin
            next = REFILL;
          end
        end else begin
          if (hit) begin
            sram_wr_en      = 1'b1;
            sram_wr_addr    = {req_index, req_word};
            sram_wr_data    = req_wdata;
            sram_wr_byte_en = req_be;
          end
          next = WRITE_MEM;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {req_addr[ADDR_WIDTH-1:4], beat, 2'b00};
        if (mem_ack) begin
          sram_wr_en      = 1'b1;
          sram_wr_addr    = {req_index, beat};
          sram_wr_data    = mem_rdata;
          sram_wr_byte_en = 4'hF;
          if (beat == 2'd3) next = RESP;
        end
      end
      RESP: begin
        cpu_ready = 1'b1;
        cpu_rdata = cap_q;
        next      = IDLE;
      end
      WRITE_MEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {req_addr, 2'b00};
        mem_wdata = req_wdata;
        mem_be    = req_be;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          next      = IDLE;
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      beat    <= '0;
      valid   <= '0;
      rdata_q <= '0;
    end else begin
      state <= next;
      if (state == IDLE) beat <= '0;
      else if (state == REFILL && mem_ack) beat <= beat + 2'd1;
      // A line becomes valid only once all four beats are in the SRAM
      if (flush_now) valid <= '0;
      else if (state == REFILL && mem_ack && beat == 2'd3) valid[req_index] <= 1'b1;
      if (cpu_ready) rdata_q <= cpu_rdata;
    end
  end

`ifdef DCACHE_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush_pend <= 1'b0;
    else if (flush_now) flush_pend <= 1'b0;
    else if (flush_req && state != IDLE) flush_pend <= 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (state == IDLE && cpu_req && !flush_go) begin
      req_we    <= cpu_we;
      req_addr  <= cpu_addr[ADDR_WIDTH-1:2];
      req_wdata <= cpu_wdata;
      req_be    <= cpu_be;
    end
    if (state == REFILL && mem_ack) begin
      if (beat == req_word) cap_q <= mem_rdata;
      if (beat == 2'd3) tag_mem[req_index] <= req_tag;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache/memory model; build with DCACHE_FLUSH_EN to add the flush scenario.
module tb_dcache_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0000_1234, cpu_wdata = '0;
  logic [3:0]  cpu_be = '0;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        sram_wr_en;
  logic [8:0]  sram_wr_addr, sram_rd_addr;
  logic [31:0] sram_wr_data, sram_rd_data;
  logic [3:0]  sram_wr_byte_en;
`ifdef DCACHE_FLUSH_EN
  logic        flush_req = 1'b0;
  logic        flush_busy;
`endif

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_be(cpu_be),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .sram_wr_en(sram_wr_en), .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_wr_byte_en(sram_wr_byte_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data)
`ifdef DCACHE_FLUSH_EN
    , .flush_req(flush_req), .flush_busy(flush_busy)
`endif
  );

  int n_checks = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // SRAM macro: byte-enabled write, one-cycle read latency
  logic [31:0] sram [512];
  int sram_wr_cnt = 0;
  always @(posedge clk) begin
    if (sram_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (sram_wr_byte_en[b]) sram[sram_wr_addr][8*b +: 8] <= sram_wr_data[8*b +: 8];
      sram_wr_cnt <= sram_wr_cnt + 1;
    end
    sram_rd_data <= sram[sram_rd_addr];
  end

  // Reference memory: untouched words read as 0xD000_0000 | address
  logic [31:0] mem [logic [31:0]];
  function automatic logic [31:0] mem_val(input logic [31:0] a);
    logic [31:0] w;
    w = {a[31:2], 2'b00};
    return mem.exists(w) ? mem[w] : (32'hD000_0000 | w);
  endfunction

  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$], wr_data_log[$];
  logic [3:0]  wr_be_log[$];
  bit          ack_block = 1'b0;

  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (rst_n && mem_req && !ack_block && $urandom_range(0, 2) != 0) begin
        mem_ack = 1'b1;
        if (mem_we) begin
          wr_addr_log.push_back(mem_addr);
          wr_data_log.push_back(mem_wdata);
          wr_be_log.push_back(mem_be);
        end else begin
          mem_rdata = mem_val(mem_addr);
          rd_log.push_back(mem_addr);
        end
      end else if (rst_n && !mem_req && $urandom_range(0, 7) == 0) begin
        mem_ack = 1'b1;
      end
    end
  end

  // Cache model: which tag each line holds, if any
  bit          mvalid [128];
  logic [20:0] mtag [128];
  bit          busy = 1'b0;
  logic [31:0] last_rdata = '0;

  task automatic clear_model();
    for (int i = 0; i < 128; i++) mvalid[i] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst_n && !busy) begin
      chk("idle_mem_req", mem_req, 0);
      chk("idle_sram_wr", sram_wr_en, 0);
      chk("idle_ready", cpu_ready, 0);
      chk("rdata_hold", cpu_rdata, last_rdata);
    end
  end

  task automatic do_req(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, output logic [31:0] got, output int nreads);
    int idx, cyc, sw0;
    bit hit;
    logic [31:0] exp, merged;
    idx = int'(addr[10:4]);
    hit = mvalid[idx] && (mtag[idx] == addr[31:11]);
    exp = mem_val(addr);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete(); wr_be_log.delete();
    sw0 = sram_wr_cnt;
    busy = 1'b1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_be = be;
    @(posedge clk);
    cyc = 0;
    do begin
      @(negedge clk); #1;
      cyc++;
    end while (!cpu_ready && cyc < 200);
    chk("ready_seen", cpu_ready, 1);
    got = cpu_rdata;
    nreads = rd_log.size();
    if (!we) begin
      chk("rdata", got, exp);
      chk("read_beats", nreads, hit ? 0 : 4);
      chk("refill_sram_wr", sram_wr_cnt - sw0, hit ? 0 : 4);
      if (hit) chk("hit_latency", cyc, 1);
      for (int i = 0; i < rd_log.size() && i < 4; i++)
        chk("refill_addr", rd_log[i], {addr[31:4], 4'h0} + 32'(4 * i));
      mvalid[idx] = 1'b1;
      mtag[idx] = addr[31:11];
      last_rdata = exp;
    end else begin
      chk("wr_ready_with_ack", mem_ack, 1);
      chk("wt_count", wr_addr_log.size(), 1);
      chk("wt_no_reads", nreads, 0);
      chk("wt_sram_wr", sram_wr_cnt - sw0, hit ? 1 : 0);
      if (wr_addr_log.size() > 0) begin
        chk("wt_addr", wr_addr_log[0], {addr[31:2], 2'b00});
        chk("wt_data", wr_data_log[0], wdata);
        chk("wt_be", wr_be_log[0], be);
      end
      merged = exp;
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b +: 8] = wdata[8*b +: 8];
      mem[{addr[31:2], 2'b00}] = merged;
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    busy = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int nr, cyc;
    clear_model();
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_cpu_ready", cpu_ready, 0);
    chk("rst_sram_wr", sram_wr_en, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rd_addr", sram_rd_addr, 9'h08D);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    do_req(0, 32'h0000_0124, 0, 0, got, nr);
    chk("cold_rdata", got, 32'hD000_0124);
    chk("cold_beats", nr, 4);
    chk("cold_first_addr", rd_log[0], 32'h0000_0120);
    chk("cold_last_addr", rd_log[3], 32'h0000_012C);
    do_req(0, 32'h0000_0124, 0, 0, got, nr);
    chk("rehit_beats", nr, 0);
    chk("rehit_rdata", got, 32'hD000_0124);

    do_req(1, 32'h0000_0124, 32'hAABB_CCDD, 4'b0101, got, nr);
    chk("wh_mem_be", wr_be_log[0], 4'b0101);
    do_req(0, 32'h0000_0124, 0, 0, got, nr);
    chk("merge_rdata", got, 32'hD0BB_01DD);
    chk("merge_beats", nr, 0);

    do_req(1, 32'h0000_2000, 32'h1234_5678, 4'hF, got, nr);
    do_req(0, 32'h0000_2000, 0, 0, got, nr);
    chk("wmiss_read_beats", nr, 4);
    chk("wmiss_read_rdata", got, 32'h1234_5678);

    do_req(0, 32'h0000_0100, 0, 0, got, nr);
    chk("conf_a_beats", nr, 4);
    do_req(0, 32'h0000_0900, 0, 0, got, nr);
    chk("conf_b_beats", nr, 4);
    chk("conf_b_rdata", got, 32'hD000_0900);
    do_req(0, 32'h0000_0100, 0, 0, got, nr);
    chk("conf_a2_beats", nr, 4);

    // Reset in the middle of a refill
    rd_log.delete();
    busy = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_05A0;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (rd_log.size() < 2 && cyc < 200);
    chk("midrefill_two_acks", rd_log.size(), 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_ready", cpu_ready, 0);
    cpu_req = 1'b0;
    clear_model();
    last_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    busy = 1'b0;
    @(posedge clk); #1;
    do_req(0, 32'h0000_05A0, 0, 0, got, nr);
    chk("postrst_beats", nr, 4);
    chk("postrst_rdata", got, 32'hD000_05A0);

`ifdef DCACHE_FLUSH_EN
    do_req(0, 32'h0000_0300, 0, 0, got, nr);
    do_req(0, 32'h0000_0300, 0, 0, got, nr);
    chk("fl_hit_beats", nr, 0);
    ack_block = 1'b1;
    fork
      do_req(1, 32'h0000_0300, 32'h0BAD_F00D, 4'hF, got, nr);
      begin
        repeat (3) @(posedge clk);
        #2 flush_req = 1'b1;
        @(posedge clk);
        #2 flush_req = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("flush_busy_set", flush_busy, 1);
        ack_block = 1'b0;
      end
    join
    @(posedge clk); #1;
    chk("flush_busy_clr", flush_busy, 0);
    clear_model();
    do_req(0, 32'h0000_0300, 0, 0, got, nr);
    chk("fl_after_beats", nr, 4);
    chk("fl_after_rdata", got, 32'h0BAD_F00D);
`endif

    for (int t = 0; t < 300; t++) begin
      logic [31:0] a;
      a = 32'h4000_0000 | (32'($urandom_range(0, 3)) << 11) | (32'($urandom_range(0, 3)) << 4)
          | (32'($urandom_range(0, 3)) << 2);
      do_req($urandom_range(0, 2) == 0, a, $urandom, 4'($urandom), got, nr);
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
